// File: rtl/vme_dtb_responder.sv
// VME data-transfer-bus slave: decodes A24 (geographic) and A32 accesses,
// hands each hit to a local request/acknowledge port and answers with DTACKn/BERRn.
module vme_dtb_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 255,
  parameter logic [7:0] BASE_A32    = 8'h55
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] ADDRBUS,
  input  logic [5:0]  VME_AM,
  input  logic        VME_ASn,
  input  logic        DS0n,
  input  logic        DS1n,
  input  logic        VME_R_Wn,
  input  logic        LWORDn,
  input  logic [4:0]  GA,
  input  logic [31:0] VME_DATA_I,
  output logic [31:0] VME_DATA_O,
  output logic        VME_DATA_OE,
  output logic        DTACKn,
  output logic        BERRn,
  output logic        LOC_REQ,
  output logic        LOC_WE,
  output logic [23:0] LOC_ADDR,
  output logic [3:0]  LOC_BE,
  output logic [31:0] LOC_WDATA,
  input  logic [31:0] LOC_RDATA,
  input  logic        LOC_ACK
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, DECODE, WAIT_DS, REQ, WAIT_ACK, DRIVE, ACK, ERR, WAIT_AS
  } state_t;

  function automatic logic [3:0] byte_en(input logic lword, input logic a1);
    if (!lword) return 4'hF;
    return a1 ? 4'h3 : 4'hC;
  endfunction

  // Stage p0..pN: strobe synchronizers; vld_p marks when they hold real bus samples
  logic [SYNC_STAGES-1:0] as_p, ds0_p, ds1_p, rw_p, vld_p;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      as_p  <= '1;
      ds0_p <= '1;
      ds1_p <= '1;
      rw_p  <= '1;
      vld_p <= '0;
    end else begin
      as_p  <= SYNC_STAGES'({as_p,  VME_ASn});
      ds0_p <= SYNC_STAGES'({ds0_p, DS0n});
      ds1_p <= SYNC_STAGES'({ds1_p, DS1n});
      rw_p  <= SYNC_STAGES'({rw_p,  VME_R_Wn});
      vld_p <= SYNC_STAGES'({vld_p, 1'b1});
    end
  end

  logic as_s, ds0_s, ds1_s, rw_s, sync_ok;
  logic ds_low, ds_high, ds_one;

  assign as_s    = as_p[SYNC_STAGES-1];
  assign ds0_s   = ds0_p[SYNC_STAGES-1];
  assign ds1_s   = ds1_p[SYNC_STAGES-1];
  assign rw_s    = rw_p[SYNC_STAGES-1];
  assign sync_ok = vld_p[SYNC_STAGES-1];
  assign ds_low  = !ds0_s && !ds1_s;
  assign ds_high = ds0_s && ds1_s;
  assign ds_one  = ds0_s ^ ds1_s;

  // Stage decode: address-phase values captured when AS first falls
  state_t           state;
  logic [31:0]      addr_q;
  logic [5:0]       am_q;
  logic             lword_q, rw_q, armed;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = ((am_q == 6'h2F) && (addr_q[23:19] == ~GA)) ||
               ((am_q == 6'h09) && (addr_q[31:24] == BASE_A32));

  // Stage transfer: armed blocks decoding until AS has been seen high after reset
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      DTACKn      <= 1'b1;
      BERRn       <= 1'b1;
      VME_DATA_OE <= 1'b0;
      VME_DATA_O  <= '0;
      LOC_REQ     <= 1'b0;
      LOC_WE      <= 1'b0;
      LOC_ADDR    <= '0;
      LOC_BE      <= '0;
      LOC_WDATA   <= '0;
      cnt         <= '0;
      armed       <= 1'b0;
      addr_q      <= '0;
      am_q        <= '0;
      lword_q     <= 1'b1;
      rw_q        <= 1'b1;
    end else begin
      LOC_REQ <= 1'b0;
      if (sync_ok && as_s) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && !as_s) begin
            addr_q  <= ADDRBUS;
            am_q    <= VME_AM;
            lword_q <= LWORDn;
            rw_q    <= rw_s;
            state   <= DECODE;
          end
        end
        DECODE: state <= hit ? WAIT_DS : WAIT_AS;
        WAIT_DS: begin
          if (as_s) begin
            state <= IDLE;
          end else if (ds_low) begin
            LOC_REQ   <= 1'b1;
            LOC_WE    <= ~rw_q;
            LOC_WDATA <= VME_DATA_I;
            LOC_ADDR  <= addr_q[23:0];
            LOC_BE    <= byte_en(lword_q, addr_q[1]);
            state     <= REQ;
          end else if (ds_one) begin
            BERRn <= 1'b0;
            state <= ERR;
          end
        end
        REQ: begin
          if (as_s) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(1);
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (as_s) begin
            state <= IDLE;
          end else if (LOC_ACK) begin
            if (rw_q) begin
              VME_DATA_O  <= LOC_RDATA;
              VME_DATA_OE <= 1'b1;
              state       <= DRIVE;
            end else begin
              DTACKn <= 1'b0;
              state  <= ACK;
            end
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            BERRn <= 1'b0;
            state <= ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          DTACKn <= 1'b0;
          state  <= ACK;
        end
        ACK: begin
          if (ds_high) begin
            DTACKn      <= 1'b1;
            VME_DATA_OE <= 1'b0;
            state       <= WAIT_AS;
          end
        end
        ERR: begin
          if (ds_high) begin
            BERRn <= 1'b1;
            state <= WAIT_AS;
          end
        end
        WAIT_AS: if (as_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
